// File: rtl/alu_ctrl_seq.sv
// Multi-cycle control sequencer for the datapath ALU: fetches 9-bit instructions,
// decodes ALU commands and write strobes, sequences data-memory requests and owns the pc.
module alu_ctrl_seq #(
    parameter int unsigned PW = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [8:0]    instr,
    input  logic          alu_rslt0,
    input  logic          mem_ack,
    output logic [PW-1:0] pc,
    output logic [3:0]    alu_cmd,
    output logic [2:0]    rf_addr,
    output logic          acc_we,
    output logic          rf_we,
    output logic          mem_req,
    output logic          mem_we,
    output logic          done,
    output logic          illegal
);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StExec,
        StMem,
        StHalt
    } state_e;

    localparam logic [3:0] OpNop  = 4'h0;
    localparam logic [3:0] OpXor  = 4'h1;
    localparam logic [3:0] OpBne  = 4'h2;
    localparam logic [3:0] OpAdd  = 4'h3;
    localparam logic [3:0] OpLsh  = 4'h4;
    localparam logic [3:0] OpRsh  = 4'h5;
    localparam logic [3:0] OpMov  = 4'h6;
    localparam logic [3:0] OpPar  = 4'h7;
    localparam logic [3:0] OpLd   = 4'h8;
    localparam logic [3:0] OpSt   = 4'h9;
    localparam logic [3:0] OpHalt = 4'hF;

    localparam logic [3:0] CmdXor  = 4'd1;
    localparam logic [3:0] CmdBne  = 4'd2;
    localparam logic [3:0] CmdAdd  = 4'd3;
    localparam logic [3:0] CmdLsh  = 4'd4;
    localparam logic [3:0] CmdRsh  = 4'd5;
    localparam logic [3:0] CmdPass = 4'd7;
    localparam logic [3:0] CmdPar  = 4'd8;

    localparam logic [PW-1:0] PcOne = PW'(1);

    state_e        state_q, state_d;
    logic [PW-1:0] pc_q, pc_d;
    logic [8:0]    ir_q, ir_d;

    logic [3:0]    op;
    logic [3:0]    fetch_op;
    logic [PW-1:0] br_offset;

    assign op        = ir_q[8:5];
    assign fetch_op  = instr[8:5];
    // Branch offset is the 5-bit operand sign-extended to pc width; the add wraps mod 2^PW.
    assign br_offset = {{(PW - 5){ir_q[4]}}, ir_q[4:0]};

    // State, pc and instruction registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            pc_q    <= '0;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    // Next-state, pc and ir update.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        case (state_q)
            StIdle, StHalt: begin
                if (start) begin
                    state_d = StFetch;
                    pc_d    = '0;
                end
            end
            StFetch: begin
                ir_d    = instr;
                state_d = (fetch_op == OpLd || fetch_op == OpSt) ? StMem : StExec;
            end
            StExec: begin
                if (op == OpHalt) begin
                    state_d = StHalt;
                end else begin
                    state_d = StFetch;
                    if (op == OpBne && alu_rslt0) begin
                        pc_d = pc_q + br_offset;
                    end else begin
                        pc_d = pc_q + PcOne;
                    end
                end
            end
            StMem: begin
                if (mem_ack) begin
                    state_d = StFetch;
                    pc_d    = pc_q + PcOne;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Output decode from state and ir; quiescent outside EXEC/MEM.
    always_comb begin
        alu_cmd = CmdPass;
        rf_addr = ir_q[2:0];
        acc_we  = 1'b0;
        rf_we   = 1'b0;
        mem_req = 1'b0;
        mem_we  = 1'b0;
        illegal = 1'b0;
        done    = (state_q == StHalt);
        case (state_q)
            StExec: begin
                case (op)
                    OpNop:  alu_cmd = CmdPass;
                    OpXor:  begin alu_cmd = CmdXor; acc_we = 1'b1; end
                    OpBne:  alu_cmd = CmdBne;
                    OpAdd:  begin alu_cmd = CmdAdd; acc_we = 1'b1; end
                    OpLsh:  begin alu_cmd = CmdLsh; acc_we = 1'b1; end
                    OpRsh:  begin alu_cmd = CmdRsh; acc_we = 1'b1; end
                    OpMov:  begin alu_cmd = CmdPass; rf_we = 1'b1; end
                    OpPar:  begin alu_cmd = CmdPar; acc_we = 1'b1; end
                    // LD/ST never reach EXEC; HALT only changes state.
                    OpLd, OpSt, OpHalt: alu_cmd = CmdPass;
                    default: illegal = 1'b1;
                endcase
            end
            StMem: begin
                mem_req = 1'b1;
                mem_we  = (op == OpSt);
                acc_we  = (op == OpLd) && mem_ack;
            end
            default: ;
        endcase
    end

    assign pc = pc_q;

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Self-checking bench for alu_ctrl_seq: instruction-level reference model, directed programs
// for the corner cases, then a random program with random memory latency and branch outcomes.
module tb_alu_ctrl_seq;

    localparam int unsigned PW = 10;
    localparam int PcMod = 1 << PW;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [8:0]    instr;
    logic          alu_rslt0;
    logic          mem_ack;
    logic [PW-1:0] pc;
    logic [3:0]    alu_cmd;
    logic [2:0]    rf_addr;
    logic          acc_we;
    logic          rf_we;
    logic          mem_req;
    logic          mem_we;
    logic          done;
    logic          illegal;

    logic [8:0] rom [PcMod];

    int n_checks = 0;
    int n_errors = 0;
    int m_pc     = 0;
    bit m_halted = 1'b0;

    alu_ctrl_seq #(.PW(PW)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .instr    (instr),
        .alu_rslt0(alu_rslt0),
        .mem_ack  (mem_ack),
        .pc       (pc),
        .alu_cmd  (alu_cmd),
        .rf_addr  (rf_addr),
        .acc_we   (acc_we),
        .rf_we    (rf_we),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .done     (done),
        .illegal  (illegal)
    );

    assign instr = rom[pc];

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [8:0] mk(input int op, input int opr);
        return 9'(((op & 15) << 5) | (opr & 31));
    endfunction

    // ALU command expected in EXEC for each opcode.
    function automatic int exp_cmd(input int op);
        case (op)
            1: return 1;
            2: return 2;
            3: return 3;
            4: return 4;
            5: return 5;
            7: return 8;
            default: return 7;
        endcase
    endfunction

    function automatic bit exp_acc(input int op);
        return op == 1 || op == 3 || op == 4 || op == 5 || op == 7;
    endfunction

    task automatic clear_rom();
        for (int i = 0; i < PcMod; i++) rom[i] = mk(0, 0);
    endtask

    task automatic start_prog();
        start = 1'b1;
        step();
        start = 1'b0;
        m_pc     = 0;
        m_halted = 1'b0;
    endtask

    // Executes one instruction starting in its FETCH cycle. delay = cycles until mem_ack
    // for LD/ST; rslt = forced alu_rslt0 (0/1) or -1 for random.
    task automatic run_instr(input int delay, input int rslt);
        logic [8:0] w;
        int op;
        int opr;
        int off;
        w   = rom[m_pc];
        op  = int'(w[8:5]);
        opr = int'(w[4:0]);
        check("fetch_pc", pc, m_pc);
        check("fetch_cmd", alu_cmd, 7);
        check("fetch_strobes", {acc_we, rf_we, mem_req, illegal, done}, 0);
        step();
        if (op == 8 || op == 9) begin
            for (int i = 1; i <= delay; i++) begin
                mem_ack = (i == delay);
                start   = 1'($urandom_range(0, 1));
                #1;
                check("mem_req", mem_req, 1);
                check("mem_we", mem_we, (op == 9));
                check("mem_rf_addr", rf_addr, opr & 7);
                check("mem_acc_we", acc_we, (op == 8 && i == delay));
                check("mem_rf_we", rf_we, 0);
                check("mem_pc", pc, m_pc);
                step();
                mem_ack = 1'b0;
                start   = 1'b0;
            end
            m_pc = (m_pc + 1) % PcMod;
        end else begin
            alu_rslt0 = (rslt < 0) ? 1'($urandom_range(0, 1)) : rslt[0];
            mem_ack   = 1'($urandom_range(0, 1));
            start     = 1'($urandom_range(0, 1));
            #1;
            check("exec_cmd", alu_cmd, exp_cmd(op));
            check("exec_acc_we", acc_we, exp_acc(op));
            check("exec_rf_we", rf_we, (op == 6));
            check("exec_rf_addr", rf_addr, opr & 7);
            check("exec_illegal", illegal, (op >= 10 && op <= 14));
            check("exec_mem_req", mem_req, 0);
            check("exec_pc", pc, m_pc);
            check("exec_done", done, 0);
            if (op == 15) begin
                m_halted = 1'b1;
            end else if (op == 2 && alu_rslt0) begin
                off  = (opr >= 16) ? opr - 32 : opr;
                m_pc = (m_pc + off + PcMod) % PcMod;
            end else begin
                m_pc = (m_pc + 1) % PcMod;
            end
            step();
            mem_ack   = 1'b0;
            start     = 1'b0;
            alu_rslt0 = 1'b0;
            if (m_halted) begin
                #1;
                check("halt_done", done, 1);
                check("halt_pc", pc, m_pc);
                check("halt_cmd", alu_cmd, 7);
            end
        end
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        alu_rslt0 = 1'b0;
        mem_ack   = 1'b0;
        clear_rom();
        step();
        step();
        reset = 1'b0;
        check("rst_pc", pc, 0);
        check("rst_cmd", alu_cmd, 7);
        check("rst_rf_addr", rf_addr, 0);
        check("rst_strobes", {acc_we, rf_we, mem_req, mem_we, done, illegal}, 0);
        step();
        check("idle_pc", pc, 0);
        check("idle_cmd", alu_cmd, 7);

        // ADD r1; MOV r2; HALT
        rom[0] = mk(3, 1);
        rom[1] = mk(6, 2);
        rom[2] = mk(15, 0);
        start_prog();
        for (int i = 0; i < 3; i++) run_instr(1, -1);
        step();
        check("halt_hold_pc", pc, 2);
        check("halt_hold_done", done, 1);

        // Restart from HALT; BNE -3 at pc 5 taken then not taken.
        clear_rom();
        rom[5] = mk(2, -3);
        rom[6] = mk(15, 0);
        start_prog();
        check("restart_pc", pc, 0);
        check("restart_done", done, 0);
        for (int i = 0; i < 5; i++) run_instr(1, -1);
        run_instr(1, 1);
        check("bne_taken_pc", pc, 2);
        for (int i = 0; i < 3; i++) run_instr(1, -1);
        run_instr(1, 0);
        check("bne_not_taken_pc", pc, 6);
        run_instr(1, -1);

        // Negative wrap below 0, then positive wrap past 2^PW-1.
        clear_rom();
        rom[0]         = mk(2, -4);
        rom[PcMod - 4] = mk(2, 15);
        rom[11]        = mk(15, 0);
        start_prog();
        run_instr(1, 1);
        check("wrap_neg_pc", pc, PcMod - 4);
        run_instr(1, 1);
        check("wrap_pos_pc", pc, 11);
        run_instr(1, -1);

        // Illegal opcode, PAR, LD with delayed ack, ST aborted by reset.
        clear_rom();
        rom[0] = mk(12, 0);
        rom[1] = mk(7, 0);
        rom[2] = mk(8, 3);
        rom[3] = mk(9, 5);
        start_prog();
        run_instr(1, -1);
        check("illegal_next_pc", pc, 1);
        run_instr(1, -1);
        run_instr(3, -1);
        check("ld_next_pc", pc, 3);
        step();
        check("st_mem1_req", mem_req, 1);
        check("st_mem1_we", mem_we, 1);
        check("st_mem1_rf_addr", rf_addr, 5);
        step();
        check("st_mem2_req", mem_req, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("st_rst_req", mem_req, 0);
        check("st_rst_pc", pc, 0);
        check("st_rst_rf_addr", rf_addr, 0);
        check("st_rst_done", done, 0);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        check("late_ack_req", mem_req, 0);
        check("late_ack_acc", acc_we, 0);
        step();
        step();
        check("late_ack_pc", pc, 0);
        check("late_ack_illegal", illegal, 0);

        // Random program with random memory latency and branch outcomes.
        for (int i = 0; i < PcMod; i++) begin
            rom[i] = mk(int'($urandom_range(0, 15)), int'($urandom_range(0, 31)));
        end
        start_prog();
        for (int n = 0; n < 300; n++) begin
            if (m_halted) start_prog();
            run_instr(int'($urandom_range(1, 4)), -1);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_ctrl_seq.md
# alu_ctrl_seq

Multi-cycle control sequencer that drives the 4-bit `alu_cmd` bus and the result-capture enables around the datapath ALU. It fetches 9-bit instructions and decodes them into ALU commands, register-file and accumulator write strobes, and data-memory requests. It also resolves BNE using the ALU result bit 0. It sits between the instruction ROM, the register file, the ALU and data memory, and owns the program counter.

## Interface
- PW, 10, program-counter width (instruction address bits).
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin execution at pc=0; honoured only in IDLE or HALT.
- instr  in  9  instruction ROM data for address `pc`; valid combinationally in FETCH.
- alu_rslt0  in  1  bit 0 of the ALU result; used only during BNE execute.
- mem_ack  in  1  data memory completes the current request this cycle.
- pc  out  PW  current instruction address.
- alu_cmd  out  4  ALU command: 1 xor, 2 bne-test, 3 add, 4 lshift, 5 rshift, 6 pass B, 7 pass A/nop, 8 parity.
- rf_addr  out  3  register-file operand/destination index, equal to ir[2:0].
- acc_we  out  1  write ALU result (or load data) into accumulator.
- rf_we  out  1  write ALU result into rf[rf_addr].
- mem_req  out  1  data memory request, held until acknowledged.
- mem_we  out  1  1 = store, 0 = load; valid while mem_req=1.
- done  out  1  high while in HALT.
- illegal  out  1  one-cycle pulse on decode of an undefined opcode.

## Operation
- Instruction format: opcode = instr[8:5]; operand = instr[4:0]. Register index = operand[2:0]. Branch offset = operand as signed 5-bit value (-16..+15).
- Opcodes map as follows:
  - 0x0 NOP: alu_cmd 7, no write.
  - 0x1 XOR, 0x3 ADD, 0x4 LSH, 0x5 RSH: alu_cmd 1, 3, 4, 5 respectively; acc_we.
  - 0x2 BNE: alu_cmd 2, no write.
  - 0x6 MOV: alu_cmd 7; rf_we. Writes acc into rf[idx].
  - 0x7 PAR: alu_cmd 8; acc_we.
  - 0x8 LD: mem_req with mem_we=0; acc_we on ack.
  - 0x9 ST: mem_req with mem_we=1.
  - 0xF HALT.
  - 0xA–0xE: illegal. Executes as NOP and pulses `illegal`.
- FSM states and transitions:
  - IDLE: outputs quiescent. On start → FETCH with pc=0.
  - FETCH: latch instr into ir. → EXEC, or → MEM if opcode is LD/ST.
  - EXEC: drive decoded alu_cmd and write strobe for exactly one cycle. Update pc, then → FETCH. HALT opcode goes → HALT with pc unchanged.
  - MEM: hold mem_req/mem_we/rf_addr stable until mem_ack=1. In the ack cycle: assert acc_we for LD, pc <= pc+1, → FETCH.
  - HALT: done=1. On start → FETCH with pc=0.
- PC update:
  - Default pc+1.
  - BNE: if alu_rslt0=1 in EXEC, pc <= pc + sext(offset); else pc+1.
  - All arithmetic is modulo 2^PW: wrap from 2^PW-1 to 0, and negative offsets wrap below 0.
- Outputs are decoded combinationally from state and ir. Outside EXEC/MEM, alu_cmd=7 and all strobes are 0.
- start while in FETCH/EXEC/MEM is ignored.
- mem_ack outside MEM is ignored.

## Timing
- Reset values:
  - Registers: state=IDLE, pc=0, ir=0.
  - Outputs: alu_cmd=7, rf_addr=0, acc_we=0, rf_we=0, mem_req=0, mem_we=0, done=0, illegal=0.
- Reset takes effect at the clock edge where reset=1 and has priority over start/mem_ack. Reset during MEM drops mem_req in the following cycle; the in-flight access is abandoned.
- Latency:
  - ALU/NOP/BNE/MOV/illegal: 2 cycles (FETCH, EXEC).
  - LD/ST: 1 + N cycles, where N ≥ 1 is cycles until mem_ack. mem_ack in the first MEM cycle gives 2 cycles total.
  - HALT: FETCH + EXEC, then done=1 from the next cycle.
- start → first FETCH cycle: 1 cycle.
- `illegal` is high exactly during the EXEC cycle of the offending instruction.

## Test plan
- Reset then start, program ADD r1; MOV r2; HALT → alu_cmd sequence 3, 7, 7; acc_we in cycle 2; rf_we with rf_addr=2 in cycle 4; done=1 from cycle 7; pc=2 throughout HALT.
- BNE offset -3 at pc=5: alu_rslt0=1 → next pc=2; alu_rslt0=0 → next pc=6. BNE +15 at pc=2^PW-4 with taken branch → pc=11 (wrap).
- LD r3 with mem_ack delayed 3 cycles → mem_req=1, mem_we=0, rf_addr=3 held for 3 cycles; acc_we only in the ack cycle; pc increments once.
- ST followed by reset asserted in the second MEM cycle → next cycle state IDLE, mem_req=0, pc=0; a late mem_ack causes no change.
- Opcode 0xC → illegal pulses for one cycle, no strobes, pc+1. Opcode 0x7 → alu_cmd=8 with acc_we.
- start pulsed during EXEC is ignored. start in HALT → pc=0 and FETCH on the next cycle, done=0.
